// File: rtl/valu_elem_sequencer.sv
// Issue stage for the vector FP ALU: walks a command's operand pairs through a registered
// operand stage (S1) into the combinational ALU and captures results in an output stage (S2).
module valu_elem_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a_operand,
  output logic [DATA_W-1:0] alu_b_operand,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_exception,
  input  logic              alu_overflow,
  input  logic              alu_underflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_exception,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic [LEN_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              sticky_exception,
  output logic              sticky_overflow,
  output logic              sticky_underflow
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e             r_state, w_state_d;
  logic [OP_W-1:0]    r_op;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_issue_cnt;
  logic [LEN_W-1:0]   r_retire_cnt;
  logic [2:0]         r_sticky;

  logic               r_s1_valid;
  logic [DATA_W-1:0]  r_s1_a;
  logic [DATA_W-1:0]  r_s1_b;
  logic [OP_W-1:0]    r_s1_op;
  logic [LEN_W-1:0]   r_s1_idx;
  logic               r_s1_last;

  logic               r_s2_valid;
  logic [DATA_W-1:0]  r_s2_result;
  logic [2:0]         r_s2_flags;
  logic [LEN_W-1:0]   r_s2_idx;
  logic               r_s2_last;

  logic w_cmd_fire, w_in_fire, w_s2_adv, w_out_fire, w_final_retire, w_in_ready;

  assign w_cmd_fire     = cmd_valid & (r_state == StIdle);
  assign w_s2_adv       = r_s1_valid & (~r_s2_valid | out_ready);
  assign w_out_fire     = r_s2_valid & out_ready;
  assign w_in_ready     = (r_state == StRun) & (r_issue_cnt < r_len) & (~r_s1_valid | w_s2_adv);
  assign w_in_fire      = in_valid & w_in_ready;
  assign w_final_retire = w_out_fire & (r_retire_cnt == r_len - LEN_W'(1));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (cmd_valid) w_state_d = (cmd_len == '0) ? StFinish : StRun;
      StRun:    if (w_final_retire) w_state_d = StFinish;
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_op         <= '0;
      r_len        <= '0;
      r_issue_cnt  <= '0;
      r_retire_cnt <= '0;
      r_sticky     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_op      <= '0;
      r_s1_idx     <= '0;
      r_s1_last    <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_flags   <= '0;
      r_s2_idx     <= '0;
      r_s2_last    <= 1'b0;
    end else begin
      r_state <= w_state_d;

      if (w_cmd_fire) begin
        r_op         <= cmd_op;
        r_len        <= cmd_len;
        r_issue_cnt  <= '0;
        r_retire_cnt <= '0;
        r_sticky     <= '0;
      end

      if (w_in_fire) begin
        r_s1_a      <= in_a;
        r_s1_b      <= in_b;
        r_s1_op     <= r_op;
        r_s1_idx    <= r_issue_cnt;
        r_s1_last   <= (r_issue_cnt == r_len - LEN_W'(1));
        r_issue_cnt <= r_issue_cnt + LEN_W'(1);
      end

      // S1 refills on the same edge that S2 captures its previous occupant.
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_adv) begin
        r_s2_valid  <= 1'b1;
        r_s2_result <= alu_result;
        r_s2_flags  <= {alu_exception, alu_overflow, alu_underflow};
        r_s2_idx    <= r_s1_idx;
        r_s2_last   <= r_s1_last;
      end else if (w_out_fire) begin
        r_s2_valid <= 1'b0;
      end

      if (w_out_fire) begin
        r_retire_cnt <= r_retire_cnt + LEN_W'(1);
        r_sticky     <= r_sticky | r_s2_flags;
      end
    end
  end

  assign cmd_ready        = (r_state == StIdle);
  assign busy             = (r_state != StIdle);
  assign done             = (r_state == StFinish);
  assign in_ready         = w_in_ready;

  assign alu_a_operand    = r_s1_a;
  assign alu_b_operand    = r_s1_b;
  assign alu_operation    = r_s1_op;

  assign out_valid        = r_s2_valid;
  assign out_result       = r_s2_result;
  assign out_exception    = r_s2_flags[2];
  assign out_overflow     = r_s2_flags[1];
  assign out_underflow    = r_s2_flags[0];
  assign out_idx          = r_s2_idx;
  assign out_last         = r_s2_last;

  assign sticky_exception = r_sticky[2];
  assign sticky_overflow  = r_sticky[1];
  assign sticky_underflow = r_sticky[0];

endmodule

// File: doc/valu_elem_sequencer.md
Name: valu_elem_sequencer

Overview:
Upstream issue stage for the 32-bit IEEE-754 floating-point ALU in the vector accelerator. It accepts a vector command (opcode plus element count) and streams element operand pairs into the combinational ALU through a registered operand stage. It captures each ALU result and its exception/overflow/underflow flags into an output register. Results leave on a ready/valid stream with per-command sticky flags and a done pulse.

Parameters:
DATA_W, 32, operand and result width (IEEE-754 single precision)
OP_W, 4, ALU operation code width
LEN_W, 6, command element-count width; maximum vector length is 2^LEN_W-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer idle, command accepted on cmd_valid&cmd_ready
cmd_op  in  OP_W  ALU operation for every element of the command
cmd_len  in  LEN_W  number of elements; 0 is legal
in_valid  in  1  operand pair offered
in_ready  out  1  operand pair accepted on in_valid&in_ready
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
alu_a_operand  out  DATA_W  to ALU a_operand
alu_b_operand  out  DATA_W  to ALU b_operand
alu_operation  out  OP_W  to ALU Operation
alu_result  in  DATA_W  from ALU ALU_Output
alu_exception  in  1  from ALU Exception
alu_overflow  in  1  from ALU Overflow
alu_underflow  in  1  from ALU Underflow
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  DATA_W  registered ALU result
out_exception  out  1  per-element exception flag
out_overflow  out  1  per-element overflow flag
out_underflow  out  1  per-element underflow flag
out_idx  out  LEN_W  element index, 0-based
out_last  out  1  element is the last of the command
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse on command completion
sticky_exception  out  1  OR of out_exception over the current command
sticky_overflow  out  1  OR of out_overflow over the current command
sticky_underflow  out  1  OR of out_underflow over the current command

Behaviour:
- Reset is asynchronous and active-low (rst_n). One clock (clk). On reset, every output is 0 except cmd_ready, which is 1. State becomes IDLE. Counters and S1/S2 valid bits clear.
- Reset asserted mid-command aborts the command immediately. No done pulse. Any partial results are discarded.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch op and len, clear the sticky flags and both counters, then go to RUN. If len=0, go to FINISH instead.
  - RUN: issue and drain elements. When the final element completes its out handshake, go to FINISH.
  - FINISH: done=1 for exactly one cycle, then return to IDLE. cmd_ready=0 during FINISH. Sticky flags hold until the next command is accepted.
- Pipeline stages:
  - S1 (operand register) drives alu_a_operand, alu_b_operand and alu_operation directly.
  - S2 (result register) drives all out_* outputs.
  - When S1 is empty, the alu_* outputs hold their last values.
- Stage advance rules:
  - s2_adv = s1_valid & (~s2_valid | out_ready).
  - in_ready = RUN & (issue_cnt < len) & (~s1_valid | s2_adv).
  - The S1 load and the S2 capture of the previous element occur on the same edge, giving throughput of 1 element per cycle.
- Latency:
  - Operands accepted at edge k appear on alu_* after edge k.
  - The result and flags are captured at edge k+1 and out_valid is high after k+1.
- Output handshake:
  - While out_valid & ~out_ready, every out_* signal is held stable.
  - out_valid never drops without a handshake.
- Indexing:
  - out_idx equals the acceptance order of the element.
  - out_last = (out_idx == len-1).
- Sticky flags OR in each element's flags on its out handshake.
- Counters:
  - issue_cnt and retire_cnt are LEN_W bits wide and never wrap, because they are bounded by len.
  - Extra in_valid after len elements have issued is ignored (in_ready=0).
- cmd_valid outside IDLE is ignored.

Test Plan:
- len=1, op=4'b1010, a=4201_51EC, b=4242_147B, out_ready=1 -> out_result=42A1_B333, exception=0, out_idx=0, out_last=1. out_valid is high 1 cycle after in accept, and done pulses the cycle after the out handshake.
- len=4, continuous in_valid/out_ready -> in_ready stays high for 4 consecutive cycles. Results arrive on 4 consecutive cycles with idx 0,1,2,3, and only idx 3 has out_last. Then exactly one done pulse.
- len=4, out_ready=0 for 3 cycles after the first result -> in_ready drops once S1 and S2 are full. out_result/out_idx are held stable. All 4 results are delivered in order with no duplicates or losses.
- len=0 -> busy for exactly 1 cycle (FINISH), done=1 one cycle after cmd accept, out_valid never asserts.
- ALU model forces alu_exception=1 on element 2 of 3 -> out_exception=1 only at idx 2. sticky_exception goes to 1 and stays set through done. It clears to 0 on the next cmd accept.
- rst_n pulled low while 2 of 5 elements are outstanding -> all outputs go to 0 immediately and cmd_ready=1. After release, a new len=1 command completes normally with idx=0.
